// File: rtl/mnist_class_vote_argmax.sv
// mnist_class_vote_argmax
// Classifier back end for channel-multiplexed binary LUT networks. Each beat
// carries CLASS_NUM x CHANNEL_NUM binary votes. The block popcounts the votes
// per class, optionally sums FRAME_NUM valid beats, and reports the class with
// the most votes (lowest index on ties) plus its count and a tie flag.
//
// Ports:
//   reset      async active-high reset, clears every register
//   clk        rising-edge clock
//   cke        clock enable, low freezes all state and ignores inputs
//   in_user    sideband of the beat
//   in_data    bit [j*CLASS_NUM+i] = channel j vote for class i
//   in_valid   beat valid (no back-pressure)
//   out_user   in_user of the final beat of the decided group
//   out_index  winning class
//   out_count  accumulated vote count of the winner
//   out_tie    another class has the same count as the winner
//   out_valid  one-cycle pulse per decided group
//
// Pipeline: popcount -> accumulate -> argmax, one register stage each.
`timescale 1ns/1ps
module mnist_class_vote_argmax #(
  parameter int USER_WIDTH  = 8,
  parameter int CLASS_NUM   = 10,
  parameter int CHANNEL_NUM = 7,
  parameter int FRAME_NUM   = 1,
  parameter int INDEX_WIDTH = $clog2(CLASS_NUM),
  parameter int COUNT_WIDTH = $clog2(CHANNEL_NUM * FRAME_NUM + 1)
) (
  input  logic                             reset,
  input  logic                             clk,
  input  logic                             cke,
  input  logic [USER_WIDTH-1:0]            in_user,
  input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
  input  logic                             in_valid,
  output logic [USER_WIDTH-1:0]            out_user,
  output logic [INDEX_WIDTH-1:0]           out_index,
  output logic [COUNT_WIDTH-1:0]           out_count,
  output logic                             out_tie,
  output logic                             out_valid
);

  localparam int PC_WIDTH  = $clog2(CHANNEL_NUM + 1);
  // A 1-bit counter is kept even for FRAME_NUM=1 so the logic stays uniform;
  // it then never leaves 0 and every beat closes a group.
  localparam int GRP_WIDTH = (FRAME_NUM > 1) ? $clog2(FRAME_NUM) : 1;
  localparam logic [GRP_WIDTH-1:0] GRP_LAST = GRP_WIDTH'(FRAME_NUM - 1);

  // ---------------- stage 1: popcount ----------------
  logic [PC_WIDTH-1:0]    pc_s [CLASS_NUM];
  logic [PC_WIDTH-1:0]    pc_r [CLASS_NUM];
  logic                   s1_valid_r;
  logic [USER_WIDTH-1:0]  s1_user_r;

  // Per-class popcount across all channels of the incoming beat
  always_comb begin
    for (int i = 0; i < CLASS_NUM; i++) begin
      pc_s[i] = '0;
      for (int j = 0; j < CHANNEL_NUM; j++) begin
        pc_s[i] = pc_s[i] + PC_WIDTH'(in_data[j*CLASS_NUM+i]);
      end
    end
  end

  // Stage 1 registers: popcounts with valid and sideband
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_user_r  <= '0;
      for (int i = 0; i < CLASS_NUM; i++) begin
        pc_r[i] <= '0;
      end
    end else if (cke) begin
      s1_valid_r <= in_valid;
      s1_user_r  <= in_user;
      for (int i = 0; i < CLASS_NUM; i++) begin
        pc_r[i] <= pc_s[i];
      end
    end
  end

  // ---------------- stage 2: accumulate ----------------
  logic [COUNT_WIDTH-1:0] acc_next_s [CLASS_NUM];
  logic [COUNT_WIDTH-1:0] acc_r      [CLASS_NUM];
  logic [COUNT_WIDTH-1:0] sum_r      [CLASS_NUM];
  logic [GRP_WIDTH-1:0]   grp_cnt_r;
  logic                   grp_last_s;
  logic                   s2_valid_r;
  logic [USER_WIDTH-1:0]  s2_user_r;

  // Running totals including the current stage-1 beat
  always_comb begin
    for (int i = 0; i < CLASS_NUM; i++) begin
      acc_next_s[i] = acc_r[i] + COUNT_WIDTH'(pc_r[i]);
    end
    grp_last_s = (grp_cnt_r == GRP_LAST);
  end

  // Stage 2 registers: accumulate valid beats, present the sum on the group's last beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_cnt_r  <= '0;
      s2_valid_r <= 1'b0;
      s2_user_r  <= '0;
      for (int i = 0; i < CLASS_NUM; i++) begin
        acc_r[i] <= '0;
        sum_r[i] <= '0;
      end
    end else if (cke) begin
      s2_valid_r <= 1'b0;
      if (s1_valid_r) begin
        if (grp_last_s) begin
          grp_cnt_r  <= '0;
          s2_valid_r <= 1'b1;
          s2_user_r  <= s1_user_r;
          for (int i = 0; i < CLASS_NUM; i++) begin
            sum_r[i] <= acc_next_s[i];
            acc_r[i] <= '0;
          end
        end else begin
          grp_cnt_r <= grp_cnt_r + GRP_WIDTH'(1);
          for (int i = 0; i < CLASS_NUM; i++) begin
            acc_r[i] <= acc_next_s[i];
          end
        end
      end
    end
  end

  // ---------------- stage 3: argmax ----------------
  logic [INDEX_WIDTH-1:0] best_idx_s;
  logic [COUNT_WIDTH-1:0] best_cnt_s;
  logic                   best_upd_s;
  logic                   tie_s;

  // Argmax scan: replace only on strictly greater so the lowest index wins ties
  always_comb begin
    best_idx_s = '0;
    best_cnt_s = sum_r[0];
    best_upd_s = 1'b0;
    tie_s      = 1'b0;
    for (int i = 1; i < CLASS_NUM; i++) begin
      best_upd_s = (sum_r[i] > best_cnt_s);
      best_idx_s = best_upd_s ? INDEX_WIDTH'(i) : best_idx_s;
      best_cnt_s = best_upd_s ? sum_r[i] : best_cnt_s;
    end
    for (int i = 0; i < CLASS_NUM; i++) begin
      tie_s = tie_s | ((sum_r[i] == best_cnt_s) && (INDEX_WIDTH'(i) != best_idx_s));
    end
  end

  // Output registers: pulse valid per decision, hold fields between decisions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_user  <= '0;
      out_index <= '0;
      out_count <= '0;
      out_tie   <= 1'b0;
    end else if (cke) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        out_user  <= s2_user_r;
        out_index <= best_idx_s;
        out_count <= best_cnt_s;
        out_tie   <= tie_s;
      end
    end
  end

endmodule

// File: tb/tb_mnist_class_vote_argmax.sv
`timescale 1ns/1ps
module tb_mnist_class_vote_argmax;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [7:0]  in_user;
  logic [69:0] in_data;
  logic        in_valid;

  logic [7:0]  o1_user, o4_user;
  logic [3:0]  o1_index, o4_index;
  logic [2:0]  o1_count;
  logic [4:0]  o4_count;
  logic        o1_tie, o4_tie, o1_valid, o4_valid;

  logic [31:0] obs1, obs4;
  assign obs1 = {15'd0, o1_valid, o1_user, o1_index, o1_count, o1_tie};
  assign obs4 = {13'd0, o4_valid, o4_user, o4_index, o4_count, o4_tie};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mnist_class_vote_argmax #(.USER_WIDTH(8), .CLASS_NUM(10), .CHANNEL_NUM(7), .FRAME_NUM(1)) u_dut1 (
    .reset(reset), .clk(clk), .cke(cke), .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
    .out_user(o1_user), .out_index(o1_index), .out_count(o1_count), .out_tie(o1_tie), .out_valid(o1_valid)
  );

  mnist_class_vote_argmax #(.USER_WIDTH(8), .CLASS_NUM(10), .CHANNEL_NUM(7), .FRAME_NUM(4)) u_dut4 (
    .reset(reset), .clk(clk), .cke(cke), .in_user(in_user), .in_data(in_data), .in_valid(in_valid),
    .out_user(o4_user), .out_index(o4_index), .out_count(o4_count), .out_tie(o4_tie), .out_valid(o4_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp1(input logic v, input logic [7:0] u, input int idx, input int cnt, input logic tie);
    return {15'd0, v, u, idx[3:0], cnt[2:0], tie};
  endfunction

  function automatic logic [31:0] exp4(input logic v, input logic [7:0] u, input int idx, input int cnt, input logic tie);
    return {13'd0, v, u, idx[3:0], cnt[4:0], tie};
  endfunction

  // Beat with na channel votes for class ca and nb for class cb
  function automatic logic [69:0] mk(input int ca, input int na, input int cb, input int nb);
    logic [69:0] d;
    d = '0;
    for (int j = 0; j < na; j++) d[j*10+ca] = 1'b1;
    for (int j = 0; j < nb; j++) d[j*10+cb] = 1'b1;
    return d;
  endfunction

  // Reference decision for a single beat (FRAME_NUM=1)
  function automatic logic [31:0] ref1(input logic [69:0] d, input logic [7:0] u);
    int c[10];
    int mx;
    int idx;
    int ties;
    mx = 0; idx = -1; ties = 0;
    for (int i = 0; i < 10; i++) begin
      c[i] = 0;
      for (int j = 0; j < 7; j++) c[i] += int'(d[j*10+i]);
    end
    for (int i = 0; i < 10; i++) if (c[i] > mx) mx = c[i];
    for (int i = 0; i < 10; i++) begin
      if (c[i] == mx) begin
        if (idx < 0) idx = i;
        ties++;
      end
    end
    return exp1(1'b1, u, idx, mx, ties > 1);
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic beat(input logic [69:0] d, input logic [7:0] u);
    in_data  = d;
    in_user  = u;
    in_valid = 1'b1;
  endtask

  initial begin
    logic [95:0] r;
    logic [69:0] d;
    logic [31:0] e;
    logic [31:0] q[$];
    int pulses;

    // ---- reset with random inputs ----
    reset = 1'b1; cke = 1'b1; in_valid = 1'b1;
    in_user = 8'hA5;
    r = {$urandom, $urandom, $urandom};
    in_data = r[69:0];
    step(); step(); step();
    chk("reset_dut1", obs1, 32'd0);
    chk("reset_dut4", obs4, 32'd0);

    // ---- idle ----
    reset = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_valid", 32'({o1_valid, o4_valid}), 32'd0);
    end

    // ---- basic vote ----
    beat(mk(3, 5, 7, 4), 8'd3);
    step();
    in_valid = 1'b0;
    step();
    chk("basic_early", 32'(o1_valid), 32'd0);
    step();
    chk("basic", obs1, exp1(1'b1, 8'd3, 3, 5, 1'b0));
    step();
    chk("basic_hold", obs1, exp1(1'b0, 8'd3, 3, 5, 1'b0));

    // ---- tie ----
    beat(mk(2, 7, 6, 7), 8'd5);
    step(); in_valid = 1'b0; step(); step();
    chk("tie", obs1, exp1(1'b1, 8'd5, 2, 7, 1'b1));

    // ---- all zero ----
    beat(70'd0, 8'h11);
    step(); in_valid = 1'b0; step(); step();
    chk("zero", obs1, exp1(1'b1, 8'h11, 0, 0, 1'b1));

    // ---- accumulation FRAME_NUM=4 ----
    pulse_reset();
    beat(mk(1, 7, 5, 6), 8'd6); step(); chk("acc_b0", 32'(o4_valid), 32'd0);
    beat(mk(1, 0, 5, 6), 8'd7); step(); chk("acc_b1", 32'(o4_valid), 32'd0);
    beat(mk(1, 7, 5, 6), 8'd8); step(); chk("acc_b2", 32'(o4_valid), 32'd0);
    beat(mk(1, 7, 5, 6), 8'd9); step(); chk("acc_b3", 32'(o4_valid), 32'd0);
    in_valid = 1'b0;
    step(); chk("acc_lat", 32'(o4_valid), 32'd0);
    step(); chk("acc", obs4, exp4(1'b1, 8'd9, 5, 24, 1'b0));
    step(); chk("acc_pulse", obs4, exp4(1'b0, 8'd9, 5, 24, 1'b0));

    // ---- gaps and cke inside a group ----
    pulse_reset();
    beat(mk(1, 7, 5, 6), 8'd6); step();
    in_valid = 1'b0; step();
    beat(mk(1, 0, 5, 6), 8'd7); step();
    cke = 1'b0;
    beat(mk(9, 7, 0, 7), 8'hEE); step(); step();
    chk("gap_frozen", 32'(o4_valid), 32'd0);
    cke = 1'b1;
    beat(mk(1, 7, 5, 6), 8'd8); step();
    in_valid = 1'b0; step();
    beat(mk(1, 7, 5, 6), 8'd9); step();
    in_valid = 1'b0; step();
    cke = 1'b0; step(); step();
    chk("gap_stretch", 32'(o4_valid), 32'd0);
    cke = 1'b1; step();
    chk("gap", obs4, exp4(1'b1, 8'd9, 5, 24, 1'b0));
    step();
    chk("gap_pulse", 32'(o4_valid), 32'd0);

    // ---- reset mid-group ----
    pulse_reset();
    beat(mk(0, 7, 0, 0), 8'd1); step();
    beat(mk(0, 7, 0, 0), 8'd2); step();
    in_valid = 1'b0;
    pulse_reset();
    beat(mk(8, 3, 0, 0), 8'h20); step();
    beat(mk(8, 3, 0, 0), 8'h21); step();
    beat(mk(8, 3, 0, 0), 8'h22); step();
    beat(mk(8, 3, 0, 0), 8'h23); step();
    in_valid = 1'b0; step(); step();
    chk("rst_mid", obs4, exp4(1'b1, 8'h23, 8, 12, 1'b0));

    // ---- random back-to-back stream, FRAME_NUM=1 ----
    pulse_reset();
    pulses = 0;
    for (int n = 0; n < 10002; n++) begin
      if (n < 10000) begin
        r = {$urandom, $urandom, $urandom};
        d = r[69:0];
        if ((n % 3) == 0) d = d & r[95:26];
        beat(d, 8'($urandom));
        q.push_back(ref1(in_data, in_user));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (o1_valid) pulses++;
      if (n >= 2) begin
        e = q.pop_front();
        chk("stream", obs1, e);
      end
    end
    step();
    chk("stream_end", 32'(o1_valid), 32'd0);
    chk("stream_pulses", 32'(pulses), 32'd10000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
